// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and default constants for the multiplexed seven-segment scan controller.
package seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } scan_state_t;

  localparam int DEF_NUM_DIGITS = 4;
  localparam int DEF_DWELL_CYC  = 50000;
  localparam int DEF_BLANK_CYC  = 8;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Frame-load and display-drive signals between a host and the scan controller.
interface seg_scan_ctrl_if
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS
);

  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    lzb;
  logic [3:0]              bcd_out;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    pending;
  logic                    frame_done;

  modport master (
    output enable, load, bcd_in, lzb,
    input  bcd_out, digit_en, pending, frame_done
  );

  modport slave (
    input  enable, load, bcd_in, lzb,
    output bcd_out, digit_en, pending, frame_done
  );

endinterface

// File: rtl/seg_slot_timer.sv
// Loadable down-counter that stops at zero; tc flags the final cycle of an interval.
module seg_slot_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed BCD digit scanner with double-buffered frames and leading-zero blanking.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int DWELL_CYC  = DEF_DWELL_CYC,
  parameter int BLANK_CYC  = DEF_BLANK_CYC
) (
  input logic           clk,
  input logic           rst_n,
  seg_scan_ctrl_if.slave bus
);

  localparam int MAXC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int TW   = $clog2(MAXC);
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam logic [TW-1:0] DWELL_LD = TW'(DWELL_CYC - 1);
  localparam logic [TW-1:0] BLANK_LD = TW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] LAST     = IW'(NUM_DIGITS - 1);

  scan_state_t             state, state_n;
  logic [IW-1:0]           idx, idx_n;
  logic [1:0]              sync;
  logic                    ready;
  logic                    tc, tload;
  logic [TW-1:0]           tval;
  logic                    boundary;
  logic [4*NUM_DIGITS-1:0] shadow, active, act_n;
  logic                    pending_q, lzb_q, lzb_n, run;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   den_d, den_q;
  logic [3:0]              bcd_d, bcd_q;
  logic                    fd_d, fd_q;

  // Reset release passes through two flops before scanning may start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], 1'b1};
    end
  end

  assign ready = sync[1];

  seg_slot_timer #(.WIDTH(TW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tload),
    .value (tval),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OFF;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    tload   = 1'b0;
    tval    = '0;
    if (!bus.enable) begin
      state_n = OFF;
      idx_n   = '0;
      tload   = 1'b1;
    end else begin
      case (state)
        OFF: if (ready) begin
          state_n = SHOW;
          idx_n   = '0;
          tload   = 1'b1;
          tval    = DWELL_LD;
        end
        SHOW: if (tc) begin
          state_n = GAP;
          tload   = 1'b1;
          tval    = BLANK_LD;
        end
        GAP: if (tc) begin
          state_n = SHOW;
          idx_n   = (idx == LAST) ? '0 : idx + 1'b1;
          tload   = 1'b1;
          tval    = DWELL_LD;
        end
        default: begin
          state_n = OFF;
          idx_n   = '0;
        end
      endcase
    end
  end

  assign boundary = (state_n == SHOW) && (state != SHOW) && (idx_n == '0);

  // A load coinciding with a boundary lands in shadow after the old shadow moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      active    <= '0;
      pending_q <= 1'b0;
      lzb_q     <= 1'b0;
    end else begin
      active <= act_n;
      lzb_q  <= lzb_n;
      if (bus.load) begin
        shadow    <= bus.bcd_in;
        pending_q <= 1'b1;
      end else if (boundary) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign act_n = (boundary && pending_q) ? shadow : active;
  assign lzb_n = boundary ? bus.lzb : lzb_q;

  // Walk down from the top digit while digits stay zero; digit 0 is never blanked.
  always_comb begin
    run   = lzb_n;
    blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (act_n[4*i +: 4] != 4'd0) begin
        run = 1'b0;
      end
      blank[i] = run;
    end
  end

  always_comb begin
    den_d = '0;
    bcd_d = bcd_q;
    fd_d  = (state == SHOW) && (state_n == GAP) && (idx == LAST);
    case (state_n)
      OFF: bcd_d = 4'd0;
      SHOW: begin
        bcd_d = act_n[{idx_n, 2'b00} +: 4];
        if (!blank[idx_n]) begin
          den_d[idx_n] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      den_q <= '0;
      bcd_q <= '0;
      fd_q  <= 1'b0;
    end else begin
      den_q <= den_d;
      bcd_q <= bcd_d;
      fd_q  <= fd_d;
    end
  end

  assign bus.digit_en   = den_q;
  assign bus.bcd_out    = bcd_q;
  assign bus.frame_done = fd_q;
  assign bus.pending    = pending_q;

endmodule
